// File: rtl/dcache_arbiter.sv
// ============================================================================
//  Module   : dcache_arbiter
//  Purpose  : Two-port round-robin arbiter in front of a data cache, with a
//             16-entry tag table routing out-of-order completions home.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dcache_arbiter #(
   parameter int MAX_OUT  = 16,
   parameter int RR_RESET = 1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_valid,
   input  logic        req0_rw,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_data,
   input  logic [3:0]  req0_id,
   output logic        req0_ready,

   input  logic        req1_valid,
   input  logic        req1_rw,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_data,
   input  logic [3:0]  req1_id,
   output logic        req1_ready,

   output logic        mem_valid,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic [3:0]  mem_id,
   input  logic        mem_stall,

   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic [3:0]  mem_rid,

   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   output logic [3:0]  rsp0_id,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   output logic [3:0]  rsp1_id,

   output logic        busy,
   output logic        err
);

   localparam logic [4:0] c_max_out = 5'(MAX_OUT);

   logic [15:0] r_alloc;
   logic [15:0] r_owner;
   logic [3:0]  r_tid [16];
   logic        r_last;

   logic [4:0]  w_count;
   logic [3:0]  w_free_tag;
   logic        w_grant;
   logic        w_sel;
   logic        w_cpl_hit;
   logic [15:0] w_alloc_nxt;

   always_comb begin
      w_count    = '0;
      w_free_tag = '0;
      for (int i = 0; i < 16; i++)
         w_count = w_count + 5'(r_alloc[i]);
      // Scan downward so the lowest free index wins.
      for (int i = 15; i >= 0; i--)
         if (!r_alloc[i])
            w_free_tag = 4'(i);

      w_sel   = (req0_valid && req1_valid) ? ~r_last : req1_valid;
      w_grant = !rst && !mem_stall && (w_count < c_max_out) && (req0_valid || req1_valid);

      req0_ready = w_grant && !w_sel;
      req1_ready = w_grant &&  w_sel;

      w_cpl_hit = mem_rvalid && r_alloc[mem_rid];

      w_alloc_nxt = r_alloc;
      if (w_grant)
         w_alloc_nxt[w_free_tag] = 1'b1;
      if (w_cpl_hit)
         w_alloc_nxt[mem_rid] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alloc    <= '0;
         r_owner    <= '0;
         for (int i = 0; i < 16; i++)
            r_tid[i] <= '0;
         r_last     <= 1'(RR_RESET);
         mem_valid  <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         mem_id     <= '0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_id    <= '0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_id    <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         r_alloc   <= w_alloc_nxt;
         busy      <= |w_alloc_nxt;
         mem_valid <= w_grant;

         if (w_grant) begin
            r_last              <= w_sel;
            r_owner[w_free_tag] <= w_sel;
            r_tid[w_free_tag]   <= w_sel ? req1_id : req0_id;
            mem_rw              <= w_sel ? req1_rw   : req0_rw;
            mem_addr            <= w_sel ? req1_addr : req0_addr;
            mem_data            <= w_sel ? req1_data : req0_data;
            mem_id              <= w_free_tag;
         end

         // Owner/id lookups use pre-edge table contents.
         rsp0_valid <= w_cpl_hit && !r_owner[mem_rid];
         rsp1_valid <= w_cpl_hit &&  r_owner[mem_rid];
         if (w_cpl_hit && !r_owner[mem_rid]) begin
            rsp0_data <= mem_rdata;
            rsp0_id   <= r_tid[mem_rid];
         end
         if (w_cpl_hit && r_owner[mem_rid]) begin
            rsp1_data <= mem_rdata;
            rsp1_id   <= r_tid[mem_rid];
         end

         if (mem_rvalid && !r_alloc[mem_rid])
            err <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dcache_arbiter.sv
// ============================================================================
//  Module   : tb_dcache_arbiter
//  Purpose  : Scoreboard bench for dcache_arbiter against a tag-table model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_arbiter;

   localparam int TB_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_rw, req0_ready;
   logic [31:0] req0_addr, req0_data;
   logic [3:0]  req0_id;
   logic        req1_valid, req1_rw, req1_ready;
   logic [31:0] req1_addr, req1_data;
   logic [3:0]  req1_id;
   logic        mem_valid, mem_rw, mem_stall, mem_rvalid;
   logic [31:0] mem_addr, mem_data, mem_rdata;
   logic [3:0]  mem_id, mem_rid;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_data, rsp1_data;
   logic [3:0]  rsp0_id, rsp1_id;
   logic        busy, err;

   dcache_arbiter #(.MAX_OUT(TB_MAX), .RR_RESET(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
      .req0_data(req0_data), .req0_id(req0_id), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
      .req1_data(req1_data), .req1_id(req1_id), .req1_ready(req1_ready),
      .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_id(mem_id), .mem_stall(mem_stall),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rid(mem_rid),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_id(rsp0_id),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_id(rsp1_id),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { logic rw; logic [31:0] addr; logic [31:0] data; logic [3:0] id; } mem_t;
   typedef struct { logic [31:0] data; logic [3:0] id; } rsp_t;

   mem_t mem_q[$];
   rsp_t rsp_q0[$];
   rsp_t rsp_q1[$];
   mem_t last_mem;

   // Reference model: the tag table as plain arrays plus the round-robin pointer.
   bit       m_alloc [16];
   bit       m_owner [16];
   bit [3:0] m_id    [16];
   bit       m_last;
   bit       m_err;

   logic        s_rw   [2];
   logic [31:0] s_addr [2];
   logic [31:0] s_data [2];
   logic [3:0]  s_id   [2];
   logic [31:0] s_rdata;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_alloc[i]);
      return n;
   endfunction

   task automatic stage(input int p, input logic rw, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] id);
      s_rw[p] = rw; s_addr[p] = a; s_data[p] = d; s_id[p] = id;
   endtask

   task automatic stage_rand();
      for (int p = 0; p < 2; p++)
         stage(p, 1'($urandom), $urandom, $urandom, 4'($urandom));
      s_rdata = $urandom;
   endtask

   task automatic model_flush();
      for (int i = 0; i < 16; i++) begin
         m_alloc[i] = 0; m_owner[i] = 0; m_id[i] = 0;
      end
      m_last = 1'b1;
      m_err  = 1'b0;
      mem_q.delete(); rsp_q0.delete(); rsp_q1.delete();
      last_mem = '{rw: 1'b0, addr: 32'h0, data: 32'h0, id: 4'h0};
   endtask

   // One clock of stimulus: drive at negedge, predict, check ready, push expectations.
   task automatic cycle(input bit v0, input bit v1, input bit stall, input bit rv, input logic [3:0] rid);
      bit g, p, hit;
      int t;
      mem_t e;
      rsp_t r;
      @(negedge clk);
      req0_valid = v0; req0_rw = s_rw[0]; req0_addr = s_addr[0]; req0_data = s_data[0]; req0_id = s_id[0];
      req1_valid = v1; req1_rw = s_rw[1]; req1_addr = s_addr[1]; req1_data = s_data[1]; req1_id = s_id[1];
      mem_stall = stall; mem_rvalid = rv; mem_rid = rid; mem_rdata = s_rdata;
      #1;
      g = !stall && (m_count() < TB_MAX) && (v0 || v1);
      if (v0 && v1) p = (m_last == 1'b0);
      else          p = v1;
      chk("req0_ready", req0_ready, g && (p == 1'b0));
      chk("req1_ready", req1_ready, g && (p == 1'b1));

      hit = rv && m_alloc[rid];
      t = 0;
      while (t < 16 && m_alloc[t]) t++;
      if (rv && !hit) m_err = 1'b1;
      if (hit) begin
         r.data = s_rdata;
         r.id   = m_id[rid];
         if (m_owner[rid]) rsp_q1.push_back(r);
         else              rsp_q0.push_back(r);
      end
      if (g) begin
         e.rw = s_rw[p]; e.addr = s_addr[p]; e.data = s_data[p]; e.id = 4'(t);
         mem_q.push_back(e);
         m_alloc[t] = 1; m_owner[t] = p; m_id[t] = s_id[p];
         m_last = p;
      end
      if (hit) m_alloc[rid] = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 4'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; mem_stall = 1'b0; mem_rvalid = 1'b0;
      #1;
      chk("ready0_in_rst", req0_ready, 1'b0);
      chk("ready1_in_rst", req1_ready, 1'b0);
      model_flush();
      @(posedge clk); #1;
      chk("rst_mem_ctl", {mem_valid, mem_rw, mem_id}, 64'h0);
      chk("rst_mem_addr", {mem_addr, mem_data}, 64'h0);
      chk("rst_rsp0", {rsp0_valid, rsp0_id, rsp0_data}, 64'h0);
      chk("rst_rsp1", {rsp1_valid, rsp1_id, rsp1_data}, 64'h0);
      chk("rst_busy_err", {busy, err}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   // Monitor: pops expectations whenever the DUT presents (or should present) output.
   initial begin
      mem_t e;
      rsp_t r;
      bit   ev;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            ev = mem_q.size() > 0;
            chk("mem_valid", mem_valid, ev);
            if (ev) begin
               e = mem_q.pop_front();
               chk("mem_id", mem_id, e.id);
               chk("mem_req", {mem_rw, mem_addr, mem_data}, {e.rw, e.addr, e.data});
               last_mem = e;
            end else begin
               chk("mem_hold", {mem_rw, mem_id, mem_addr, mem_data},
                   {last_mem.rw, last_mem.id, last_mem.addr, last_mem.data});
            end
            ev = rsp_q0.size() > 0;
            chk("rsp0_valid", rsp0_valid, ev);
            if (ev) begin
               r = rsp_q0.pop_front();
               chk("rsp0_payload", {rsp0_id, rsp0_data}, {r.id, r.data});
            end
            ev = rsp_q1.size() > 0;
            chk("rsp1_valid", rsp1_valid, ev);
            if (ev) begin
               r = rsp_q1.pop_front();
               chk("rsp1_payload", {rsp1_id, rsp1_data}, {r.id, r.data});
            end
            chk("busy", busy, m_count() != 0);
            chk("err", err, m_err);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int       pick [$];
      logic [3:0] rid;
      int       keep;
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; mem_stall = 0; mem_rvalid = 0; mem_rid = 0;
      stage_rand();
      model_flush();
      repeat (2) @(posedge clk);
      do_reset();

      // Single load, completion two cycles later.
      stage(0, 1'b0, 32'h10, 32'h0, 4'd3);
      cycle(1, 0, 0, 0, 4'h0);
      idle(2);
      s_rdata = 32'hCAFE;
      cycle(0, 0, 0, 1, 4'd0);
      idle(2);

      // Contention from reset: grants alternate starting with port 0, until full.
      do_reset();
      stage_rand();
      repeat (5) cycle(1, 1, 0, 0, 4'h0);
      // Limit reached: completion frees tag 0, held request takes it next cycle.
      cycle(1, 0, 0, 1, 4'd0);
      cycle(1, 0, 0, 0, 4'h0);
      for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 4'(k));
      idle(1);

      // Stall holds off a waiting request.
      stage_rand();
      repeat (3) cycle(0, 1, 1, 0, 4'h0);
      cycle(0, 1, 0, 0, 4'h0);
      cycle(0, 0, 0, 1, 4'd0);
      idle(1);

      // Out-of-order completion.
      do_reset();
      stage(0, 1'b0, 32'h100, 32'h0, 4'd5);
      stage(1, 1'b1, 32'h200, 32'h55, 4'd9);
      cycle(1, 0, 0, 0, 4'h0);
      cycle(0, 1, 0, 0, 4'h0);
      s_rdata = 32'h1111; cycle(0, 0, 0, 1, 4'd1);
      s_rdata = 32'h2222; cycle(0, 0, 0, 1, 4'd0);
      idle(1);

      // Spurious completion sets a sticky error.
      cycle(0, 0, 0, 1, 4'd7);
      idle(3);

      // Randomized traffic with one mid-run reset.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         stage_rand();
         pick.delete();
         for (int k = 0; k < 16; k++) if (m_alloc[k]) pick.push_back(k);
         rid = 4'($urandom);
         if (pick.size() > 0 && ($urandom_range(0, 19) != 0))
            rid = 4'(pick[$urandom_range(0, pick.size() - 1)]);
         if (i == 1000) begin
            keep = (pick.size() > 0) ? pick[0] : 0;
            do_reset();
            cycle(0, 0, 0, 1, 4'(keep));
         end else begin
            cycle(1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 4, rid);
         end
      end
      idle(3);
      chk("mem_q_drained", 64'(mem_q.size()), 64'h0);
      chk("rsp_q_drained", 64'(rsp_q0.size() + rsp_q1.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
